// File: rtl/hsv_ctrl_pkg.sv
// Shared definitions for the HSV adjust control path: default word widths
// (also used by the HSV gain multiplier) and the gain ramp state encoding.
package hsv_ctrl_pkg;

  localparam int GAIN_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEP
  } ramp_state_e;

endpackage

// File: rtl/frame_tick.sv
// Frame-start detector and divider. A rising edge on vsync is one frame start.
// step_tick fires on the frame start that completes FRAMES_PER_STEP frames
// since the last clear.
module frame_tick #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic clr,
  output logic step_tick
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic             vsync_d;
  logic [CNT_W-1:0] frame_cnt;
  logic             frame_start;

  // A level held high only produces one frame start.
  assign frame_start = vsync & ~vsync_d;
  assign step_tick   = frame_start && (frame_cnt == CNT_LAST);

  // Delayed vsync for edge detection, and the frame counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vsync_d <= vsync;
      if (clr) begin
        frame_cnt <= '0;
      end else if (frame_start) begin
        frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsv_gain_ramp.sv
// Turns the button-counter mode index into a gain word for the HSV S/V
// multiplier. The gain moves toward its target only at frame boundaries and
// by at most RAMP_STEP per step, so a mode change never causes a visible jump.
module hsv_gain_ramp
  import hsv_ctrl_pkg::*;
#(
  parameter int SEL_W           = SEL_W_DEF,
  parameter int SEL_MAX         = 5,
  parameter int GAIN_W          = GAIN_W_DEF,
  parameter int GAIN_BASE       = 64,
  parameter int GAIN_INC        = 32,
  parameter int GAIN_MAX        = 255,
  parameter int RAMP_STEP       = 4,
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic              vsync,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_upd,
  output logic              busy
);

  // Wide enough that base + max_sel * inc cannot wrap before saturation.
  localparam int CALC_W = GAIN_W + SEL_W + 1;

  ramp_state_e       state;
  logic [GAIN_W-1:0] target_r;
  logic [SEL_W-1:0]  sel_clamped;
  logic [CALC_W-1:0] target_full;
  logic [GAIN_W-1:0] target_next;
  logic [GAIN_W-1:0] diff;
  logic [GAIN_W-1:0] step_mag;
  logic [GAIN_W-1:0] gain_next;
  logic              step_tick;
  logic              cnt_clr;

  // Target gain from the mode index, clamped in sel and saturated in gain.
  // NOTE: every always_comb output gets a value on every path, so no latch
  // is inferred.
  always_comb begin
    sel_clamped = (sel > SEL_W'(SEL_MAX)) ? SEL_W'(SEL_MAX) : sel;
    target_full = CALC_W'(GAIN_BASE) + CALC_W'(sel_clamped) * CALC_W'(GAIN_INC);
    target_next = (target_full > CALC_W'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX)
                                                    : target_full[GAIN_W-1:0];
  end

  // Next gain: one bounded step toward the target that never overshoots it.
  always_comb begin
    diff      = (target_r > gain) ? target_r - gain : gain - target_r;
    step_mag  = (diff < GAIN_W'(RAMP_STEP)) ? diff : GAIN_W'(RAMP_STEP);
    gain_next = (target_r > gain) ? gain + step_mag : gain - step_mag;
  end

  // The frame counter restarts when a ramp begins and after every step;
  // a target change in the middle of a ramp leaves it running.
  assign cnt_clr = ((state == IDLE) && (target_r != gain)) || (state == STEP);

  frame_tick #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (vsync),
    .clr      (cnt_clr),
    .step_tick(step_tick)
  );

  // Registered target and busy flag (busy lags target by one cycle).
  // NOTE: reset returns the gain path to its power-up values immediately,
  // dropping any ramp in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r <= GAIN_W'(GAIN_BASE);
      busy     <= 1'b0;
    end else begin
      target_r <= target_next;
      busy     <= (gain != target_r);
    end
  end

  // Ramp FSM; gain and its update pulse change together on entry to STEP,
  // using the target as registered in the frame-start cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gain     <= GAIN_W'(GAIN_BASE);
      gain_upd <= 1'b0;
    end else begin
      gain_upd <= 1'b0;
      case (state)
        IDLE: begin
          if (target_r != gain) state <= WAIT;
        end
        WAIT: begin
          if (target_r == gain) begin
            state <= IDLE;
          end else if (step_tick) begin
            state    <= STEP;
            gain     <= gain_next;
            gain_upd <= 1'b1;
          end
        end
        STEP: begin
          state <= (gain == target_r) ? IDLE : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
